// File: rtl/mips_defs.sv
// Shared opcode/funct constants and write-back select encodings for the MIPS-style pipeline.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_BIOAL = 6'b101101;
    localparam logic [5:0] OP_LWIE  = 6'b110011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_DM  = 2'd1,
        SEL_PC8 = 2'd2
    } wd_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_e;

endpackage

// File: rtl/wb_stage_dm_ext.sv
// Load extension: picks byte/halfword out of the aligned memory word and sign/zero extends it.
module dm_ext
    import mips_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  ld_type_e          ld_type_i,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(word_i >> {offset_i, 3'b000});
    assign half_v = 16'(word_i >> {offset_i[1], 4'b0000});

    always_comb begin
        unique case (ld_type_i)
            LD_B:    data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_v};
            LD_H:    data_o = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_v};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: M/W pipeline register, destination/data decode for the GRF port and retire counter.
module wb_stage
    import mips_defs::*;
#(
    parameter int          DATA_W = 32,
    parameter int          REG_AW = 5,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] PC_RST = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [31:0]       instr_M,
    input  logic [31:0]       pc_M,
    input  logic [DATA_W-1:0] alu_out_M,
    input  logic [DATA_W-1:0] dm_raw_M,
    input  logic              flag_M,
    output logic [31:0]       instr_W,
    output logic [31:0]       pc_W,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);
    logic [31:0]       instr_q, instr_d, pc_q, pc_d;
    logic [DATA_W-1:0] alu_q, alu_d, dm_q, dm_d;
    logic              flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Flush beats stall; a bubble never counts as retired.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        dm_d    = dm_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        if (flush) begin
            instr_d = '0;
            pc_d    = pc_M;
            alu_d   = alu_out_M;
            dm_d    = dm_raw_M;
            flag_d  = 1'b0;
        end else if (en) begin
            instr_d = instr_M;
            pc_d    = pc_M;
            alu_d   = alu_out_M;
            dm_d    = dm_raw_M;
            flag_d  = flag_M;
            if (instr_M != '0) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= PC_RST;
            alu_q   <= '0;
            dm_q    <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            dm_q    <= dm_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [5:0]        op, fn;
    logic [REG_AW-1:0] rt, rd, link;
    logic [REG_AW-1:0] dst;
    wd_sel_e           sel;
    ld_type_e          ld_type;
    logic [DATA_W-1:0] ld_data;

    assign op   = instr_q[31:26];
    assign fn   = instr_q[5:0];
    assign rt   = REG_AW'(instr_q[20:16]);
    assign rd   = REG_AW'(instr_q[15:11]);
    assign link = REG_AW'(LINK_REG);

    always_comb begin
        dst     = '0;
        sel     = SEL_ALU;
        ld_type = LD_W;
        unique case (op)
            OP_RTYPE: begin
                if (fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                               FN_OR, FN_SLT, FN_SLTU, FN_SLL}) dst = rd;
            end
            OP_ORI, OP_LUI, OP_ADDI, OP_ANDI: dst = rt;
            OP_LW:  begin dst = rt; sel = SEL_DM; ld_type = LD_W;  end
            OP_LH:  begin dst = rt; sel = SEL_DM; ld_type = LD_H;  end
            OP_LHU: begin dst = rt; sel = SEL_DM; ld_type = LD_HU; end
            OP_LB:  begin dst = rt; sel = SEL_DM; ld_type = LD_B;  end
            OP_LBU: begin dst = rt; sel = SEL_DM; ld_type = LD_BU; end
            // Conditional link target: bit0 of the loaded word picks $31 over rt.
            OP_LWIE: begin dst = dm_q[0] ? link : rt; sel = SEL_DM; end
            OP_JAL:  begin dst = link; sel = SEL_PC8; end
            OP_BIOAL: begin
                if (flag_q) begin
                    dst = link;
                    sel = SEL_PC8;
                end
            end
            default: ;
        endcase
    end

    dm_ext #(.DATA_W(DATA_W)) u_dm_ext (
        .word_i    (dm_q),
        .offset_i  (alu_q[1:0]),
        .ld_type_i (ld_type),
        .data_o    (ld_data)
    );

    always_comb begin
        unique case (sel)
            SEL_DM:  reg_wdata = ld_data;
            SEL_PC8: reg_wdata = DATA_W'(pc_q + 32'd8);
            default: reg_wdata = alu_q;
        endcase
    end

    assign reg_addr   = dst;
    assign reg_we     = (dst != '0);
    assign fwd_addr   = reg_we ? dst : '0;
    assign fwd_data   = reg_wdata;
    assign instr_W    = instr_q;
    assign pc_W       = pc_q;
    assign retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes model-predicted W state, monitor compares each cycle.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset, en, flush, flag_M;
    logic [31:0] instr_M, pc_M, alu_out_M, dm_raw_M;
    logic [31:0] instr_W, pc_W, reg_wdata, fwd_data;
    logic        reg_we;
    logic [4:0]  reg_addr, fwd_addr;
    logic [3:0]  retire_cnt;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4), .PC_RST(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .instr_M(instr_M), .pc_M(pc_M), .alu_out_M(alu_out_M), .dm_raw_M(dm_raw_M),
        .flag_M(flag_M), .instr_W(instr_W), .pc_W(pc_W), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic [31:0] instr, pc, alu, dm;
        logic        flag;
        int          cnt;
    } mstate_t;

    typedef struct {
        string       tag;
        logic [31:0] instr, pc, wdata;
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  cnt;
    } exp_t;

    mstate_t m;
    exp_t    q[$];
    int      compared = 0, mismatched = 0;
    bit      done = 0;

    // Reference: what the GRF port should show for the instruction held in W.
    function automatic exp_t predict(input mstate_t s, input string tag);
        exp_t        e;
        logic [5:0]  op = s.instr[31:26];
        logic [5:0]  fn = s.instr[5:0];
        logic [4:0]  rt = s.instr[20:16];
        logic [4:0]  rd = s.instr[15:11];
        logic [7:0]  b  = 8'((s.dm >> (8 * s.alu[1:0])) & 32'hFF);
        logic [15:0] h  = 16'((s.dm >> (16 * s.alu[1])) & 32'hFFFF);
        e.tag = tag; e.instr = s.instr; e.pc = s.pc; e.cnt = 4'(s.cnt % 16);
        e.addr = 0; e.wdata = s.alu;
        case (op)
            6'h00: if (fn inside {6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B}) e.addr = rd;
            6'h0D, 6'h0F, 6'h08, 6'h0C: e.addr = rt;
            6'h20: begin e.addr = rt; e.wdata = {{24{b[7]}}, b}; end
            6'h24: begin e.addr = rt; e.wdata = {24'h0, b}; end
            6'h21: begin e.addr = rt; e.wdata = {{16{h[15]}}, h}; end
            6'h25: begin e.addr = rt; e.wdata = {16'h0, h}; end
            6'h23: begin e.addr = rt; e.wdata = s.dm; end
            6'h33: begin e.addr = s.dm[0] ? 5'd31 : rt; e.wdata = s.dm; end
            6'h03: begin e.addr = 31; e.wdata = s.pc + 8; end
            6'h2D: if (s.flag) begin e.addr = 31; e.wdata = s.pc + 8; end
            default: ;
        endcase
        e.we = (e.addr != 0);
        return e;
    endfunction

    task automatic step(input string tag, input logic rst, input logic e_in, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] dm, input logic fg);
        @(negedge clk);
        reset = rst; en = e_in; flush = fl;
        instr_M = ins; pc_M = pc; alu_out_M = alu; dm_raw_M = dm; flag_M = fg;
        if (rst) begin
            m.instr = 0; m.pc = 32'h3000; m.alu = 0; m.dm = 0; m.flag = 0; m.cnt = 0;
        end else if (fl) begin
            m.instr = 0; m.pc = pc; m.flag = 0;
        end else if (e_in) begin
            m.instr = ins; m.pc = pc; m.alu = alu; m.dm = dm; m.flag = fg;
            if (ins != 0) m.cnt = m.cnt + 1;
        end
        @(posedge clk);
        #1 q.push_back(predict(m, tag));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, " instr_W"},    instr_W, e.instr);
                chk({e.tag, " pc_W"},       pc_W, e.pc);
                chk({e.tag, " reg_we"},     32'(reg_we), 32'(e.we));
                chk({e.tag, " reg_addr"},   32'(reg_addr), 32'(e.addr));
                chk({e.tag, " fwd_addr"},   32'(fwd_addr), e.we ? 32'(e.addr) : 32'h0);
                chk({e.tag, " retire_cnt"}, 32'(retire_cnt), 32'(e.cnt));
                if (e.we) begin
                    chk({e.tag, " reg_wdata"}, reg_wdata, e.wdata);
                    chk({e.tag, " fwd_data"},  fwd_data, e.wdata);
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h08, 6'h0C, 6'h20,
                                 6'h24, 6'h21, 6'h25, 6'h23, 6'h33, 6'h2D};
        logic [5:0] fns [9]  = '{6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
        int k = $urandom_range(0, 14);
        if (k == 13) return {6'h03, 26'($urandom)};
        if (k == 14) return ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        if (ops[k] == 6'h00)
            return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    fns[$urandom_range(0, 8)]};
        return {ops[k], 5'($urandom), 5'($urandom), 16'($urandom)};
    endfunction

    initial begin : driver
        logic [31:0] ori5;
        m = '{default: 0};
        reset = 1; en = 0; flush = 0; instr_M = 0; pc_M = 0;
        alu_out_M = 0; dm_raw_M = 0; flag_M = 0;
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 1, 1, 32'hFFFF_FFFF, 32'h1234, 1, 1, 1);
        step("addu", 0, 1, 0, 32'h0022_1821, 32'h3000, 32'h5, 0, 0);
        step("lb3",  0, 1, 0, {6'h20, 5'd0, 5'd4, 16'd3}, 32'h3004, 32'h3, 32'h80FF_FF12, 0);
        step("lbu3", 0, 1, 0, {6'h24, 5'd0, 5'd4, 16'd3}, 32'h3008, 32'h3, 32'h80FF_FF12, 0);
        step("lh2",  0, 1, 0, {6'h21, 5'd0, 5'd4, 16'd2}, 32'h300C, 32'h2, 32'h80FF_FF12, 0);
        step("lwie1", 0, 1, 0, {6'h33, 5'd0, 5'd7, 16'd0}, 32'h3010, 32'h0, 32'h1, 0);
        step("lwie2", 0, 1, 0, {6'h33, 5'd0, 5'd7, 16'd0}, 32'h3014, 32'h0, 32'h2, 0);
        step("bioal1", 0, 1, 0, {6'h2D, 5'd1, 5'd2, 16'd4}, 32'h3010, 32'h77, 0, 1);
        step("bioal0", 0, 1, 0, {6'h2D, 5'd1, 5'd2, 16'd4}, 32'h3010, 32'h77, 0, 0);
        ori5 = {6'h0D, 5'd1, 5'd5, 16'h1234};
        step("ori", 0, 1, 0, ori5, 32'h3020, 32'h1234, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 0, rand_instr(), $urandom, $urandom, $urandom, 1);
        step("flush_stall", 0, 0, 1, ori5, 32'h3024, 32'h99, 0, 1);
        step("flush_en", 0, 1, 1, ori5, 32'h3028, 32'h99, 0, 1);
        step("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++)
            step("wrap", 0, 1, 0, {6'h0D, 5'd0, 5'(i + 1), 16'(i)}, 32'h3000 + 32'(4 * i), 32'(i), 0, 0);
        step("stall_pre_rst", 0, 0, 0, ori5, 32'h4000, 1, 0, 0);
        step("rst_in_stall", 1, 0, 1, ori5, 32'h4004, 1, 0, 0);
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), rand_instr(), $urandom, $urandom,
                 $urandom, 1'($urandom));
        done = 1;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
